// File: rtl/para_arb.sv
// rtl/para_arb.sv - four-channel para_hit result arbiter with holding registers and drop counting
//
// Purpose:
//   Collects one ring value per channel from four para_hit instances, keeps the
//   oldest unserved value per channel, and presents results one at a time on a
//   valid/ready output stage in round-robin order. New values arriving for a
//   channel that is still pending are discarded and counted.
//
// Optional feature macro: PARA_ARB_STAMP_EN
//   defined   : 32-bit free-running timestamp captured per result, shown on arb_stamp
//   undefined : no timestamp logic, arb_stamp tied to 0
//
// Ports:
//   clk_sys                 system clock, rising edge
//   rst_n                   synchronous active-low reset
//   ph_ring0..ph_ring3      16-bit ring value per channel
//   ph_vld0..ph_vld3        one-cycle strobe qualifying the matching ring value
//   cfg_ch_en[3:0]          per-channel enable
//   cfg_drop_clr            one-cycle pulse clearing stu_drop
//   arb_data[15:0]          granted ring value
//   arb_ch[1:0]             channel index of arb_data
//   arb_stamp[31:0]         capture timestamp of arb_data
//   arb_vld                 output valid
//   arb_rdy                 downstream ready
//   stu_pend[3:0]           per-channel pending flags
//   stu_drop[15:0]          saturating count of discarded results

module para_arb (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic [15:0] ph_ring0,
    input  logic [15:0] ph_ring1,
    input  logic [15:0] ph_ring2,
    input  logic [15:0] ph_ring3,
    input  logic        ph_vld0,
    input  logic        ph_vld1,
    input  logic        ph_vld2,
    input  logic        ph_vld3,
    input  logic [3:0]  cfg_ch_en,
    input  logic        cfg_drop_clr,
    output logic [15:0] arb_data,
    output logic [1:0]  arb_ch,
    output logic [31:0] arb_stamp,
    output logic        arb_vld,
    input  logic        arb_rdy,
    output logic [3:0]  stu_pend,
    output logic [15:0] stu_drop
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [3:0]  w_vld;
    logic [15:0] w_ring [4];

    logic [3:0]  r_pend;
    logic [15:0] r_hold_data [4];
    logic [1:0]  r_rr_ptr;

    logic [15:0] r_arb_data;
    logic [1:0]  r_arb_ch;
    logic        r_arb_vld;
    logic [15:0] r_drop;

    logic [3:0]  w_req;
    logic        w_any;
    logic [1:0]  w_sel;
    logic        w_load;
    logic        w_xfer;
    logic [3:0]  w_grant;
    logic [3:0]  w_cap;
    logic [3:0]  w_drop;
    logic [2:0]  w_drop_cnt;
    logic [16:0] w_drop_sum;

    assign w_vld    = {ph_vld3, ph_vld2, ph_vld1, ph_vld0};
    assign w_ring[0] = ph_ring0;
    assign w_ring[1] = ph_ring1;
    assign w_ring[2] = ph_ring2;
    assign w_ring[3] = ph_ring3;

    // A disabled channel's stale pend flag must never win arbitration in the
    // same cycle it is being cleared, so requests are masked by the enable.
    assign w_req = r_pend & cfg_ch_en;

    // First requesting channel at or above rr_ptr, wrapping modulo 4.
    always_comb begin : rr_search
        logic [1:0] idx;
        idx   = '0;
        w_sel = r_rr_ptr;
        w_any = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = r_rr_ptr + 2'(i);
            if (!w_any && w_req[idx]) begin
                w_sel = idx;
                w_any = 1'b1;
            end
        end
    end

    // Output FSM: state register
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Output FSM: next state and control strobes
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_xfer      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (r_arb_vld && arb_rdy) begin
                    w_xfer      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_grant = '0;
        if (w_load) begin
            w_grant[w_sel] = 1'b1;
        end
    end

    // A channel being granted this cycle frees its holding register at the
    // same edge, so a coincident new value is accepted instead of dropped.
    assign w_cap  = w_vld & cfg_ch_en & (~r_pend | w_grant);
    assign w_drop = w_vld & cfg_ch_en & r_pend & ~w_grant;

    assign w_drop_cnt = 3'(w_drop[0]) + 3'(w_drop[1]) + 3'(w_drop[2]) + 3'(w_drop[3]);
    assign w_drop_sum = {1'b0, r_drop} + 17'(w_drop_cnt);

    // Channel holding registers, output stage and drop counter
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            r_pend     <= '0;
            r_rr_ptr   <= '0;
            r_arb_data <= '0;
            r_arb_ch   <= '0;
            r_arb_vld  <= 1'b0;
            r_drop     <= '0;
            for (int k = 0; k < 4; k++) begin
                r_hold_data[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (!cfg_ch_en[k]) begin
                    r_pend[k] <= 1'b0;
                end else if (w_cap[k]) begin
                    r_pend[k] <= 1'b1;
                end else if (w_grant[k]) begin
                    r_pend[k] <= 1'b0;
                end
                if (w_cap[k]) begin
                    r_hold_data[k] <= w_ring[k];
                end
            end

            // The output stage reads the pre-edge holding value, so a same-cycle
            // capture on the granted channel does not disturb the result sent.
            if (w_load) begin
                r_arb_data <= r_hold_data[w_sel];
                r_arb_ch   <= w_sel;
                r_arb_vld  <= 1'b1;
                r_rr_ptr   <= w_sel + 2'd1;
            end else if (w_xfer) begin
                r_arb_vld  <= 1'b0;
            end

            if (cfg_drop_clr) begin
                r_drop <= '0;
            end else if (w_drop_sum[16]) begin
                r_drop <= 16'hFFFF;
            end else begin
                r_drop <= w_drop_sum[15:0];
            end
        end
    end

`ifdef PARA_ARB_STAMP_EN
    logic [31:0] r_ts;
    logic [31:0] r_hold_stamp [4];
    logic [31:0] r_arb_stamp;

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            r_ts        <= '0;
            r_arb_stamp <= '0;
            for (int k = 0; k < 4; k++) begin
                r_hold_stamp[k] <= '0;
            end
        end else begin
            r_ts <= r_ts + 32'd1;
            for (int k = 0; k < 4; k++) begin
                if (w_cap[k]) begin
                    r_hold_stamp[k] <= r_ts;
                end
            end
            if (w_load) begin
                r_arb_stamp <= r_hold_stamp[w_sel];
            end
        end
    end

    assign arb_stamp = r_arb_stamp;
`else
    assign arb_stamp = '0;
`endif

    assign arb_data = r_arb_data;
    assign arb_ch   = r_arb_ch;
    assign arb_vld  = r_arb_vld;
    assign stu_pend = r_pend;
    assign stu_drop = r_drop;

endmodule

// File: tb/tb_para_arb.sv
// tb/tb_para_arb.sv - directed table-driven bench for para_arb

module tb_para_arb;

    logic        clk_sys = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] ph_ring0 = '0;
    logic [15:0] ph_ring1 = '0;
    logic [15:0] ph_ring2 = '0;
    logic [15:0] ph_ring3 = '0;
    logic        ph_vld0 = 1'b0;
    logic        ph_vld1 = 1'b0;
    logic        ph_vld2 = 1'b0;
    logic        ph_vld3 = 1'b0;
    logic [3:0]  cfg_ch_en = 4'hF;
    logic        cfg_drop_clr = 1'b0;
    logic [15:0] arb_data;
    logic [1:0]  arb_ch;
    logic [31:0] arb_stamp;
    logic        arb_vld;
    logic        arb_rdy = 1'b0;
    logic [3:0]  stu_pend;
    logic [15:0] stu_drop;

    int n_tests = 0;
    int n_fail  = 0;

    para_arb dut (
        .clk_sys      (clk_sys),
        .rst_n        (rst_n),
        .ph_ring0     (ph_ring0),
        .ph_ring1     (ph_ring1),
        .ph_ring2     (ph_ring2),
        .ph_ring3     (ph_ring3),
        .ph_vld0      (ph_vld0),
        .ph_vld1      (ph_vld1),
        .ph_vld2      (ph_vld2),
        .ph_vld3      (ph_vld3),
        .cfg_ch_en    (cfg_ch_en),
        .cfg_drop_clr (cfg_drop_clr),
        .arb_data     (arb_data),
        .arb_ch       (arb_ch),
        .arb_stamp    (arb_stamp),
        .arb_vld      (arb_vld),
        .arb_rdy      (arb_rdy),
        .stu_pend     (stu_pend),
        .stu_drop     (stu_drop)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic        rst;
        logic [3:0]  vld;
        logic [15:0] r0, r1, r2, r3;
        logic [3:0]  en;
        logic        rdy;
        logic        clr;
        logic        e_vld;
        logic [15:0] e_data;
        logic [1:0]  e_ch;
        logic [3:0]  e_pend;
        logic [15:0] e_drop;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, input logic [3:0] vld,
                                input logic [15:0] r0, input logic [15:0] r1,
                                input logic [15:0] r2, input logic [15:0] r3,
                                input logic [3:0] en, input logic rdy, input logic clr,
                                input logic e_vld, input logic [15:0] e_data,
                                input logic [1:0] e_ch, input logic [3:0] e_pend,
                                input logic [15:0] e_drop);
        vec_t v;
        v.rst = rst; v.vld = vld; v.r0 = r0; v.r1 = r1; v.r2 = r2; v.r3 = r3;
        v.en = en; v.rdy = rdy; v.clr = clr; v.e_vld = e_vld; v.e_data = e_data;
        v.e_ch = e_ch; v.e_pend = e_pend; v.e_drop = e_drop;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive inputs right after a falling edge, then return at the next falling
    // edge so outputs are sampled half a period after the rising edge.
    task automatic drive(input logic rst, input logic [3:0] vld,
                         input logic [15:0] r0, input logic [15:0] r1,
                         input logic [15:0] r2, input logic [15:0] r3,
                         input logic [3:0] en, input logic rdy, input logic clr);
        rst_n = ~rst;
        {ph_vld3, ph_vld2, ph_vld1, ph_vld0} = vld;
        ph_ring0 = r0; ph_ring1 = r1; ph_ring2 = r2; ph_ring3 = r3;
        cfg_ch_en = en; arb_rdy = rdy; cfg_drop_clr = clr;
        @(negedge clk_sys);
    endtask

    task automatic apply(input vec_t v, input int idx);
        drive(v.rst, v.vld, v.r0, v.r1, v.r2, v.r3, v.en, v.rdy, v.clr);
        chk($sformatf("v%0d_vld", idx), 32'(arb_vld), 32'(v.e_vld));
        chk($sformatf("v%0d_pend", idx), 32'(stu_pend), 32'(v.e_pend));
        chk($sformatf("v%0d_drop", idx), 32'(stu_drop), 32'(v.e_drop));
        if (v.e_vld) begin
            chk($sformatf("v%0d_data", idx), 32'(arb_data), 32'(v.e_data));
            chk($sformatf("v%0d_ch", idx), 32'(arb_ch), 32'(v.e_ch));
        end
`ifndef PARA_ARB_STAMP_EN
        chk($sformatf("v%0d_stamp0", idx), arb_stamp, 32'd0);
`endif
    endtask

    task automatic idle(input logic rdy);
        drive(1'b0, 4'h0, 16'h0, 16'h0, 16'h0, 16'h0, 4'hF, rdy, 1'b0);
    endtask

    task automatic flood(input logic clr);
        drive(1'b0, 4'hF, 16'h0E00, 16'h0E01, 16'h0E02, 16'h0E03, 4'hF, 1'b0, clr);
    endtask

    logic [31:0] st1, st2;

    initial begin
        // single result on ch2
        tbl.push_back(mk(0, 4'b0100, 0, 0, 16'h1234, 0, 4'hF, 1, 0, 0, 0, 0, 4'h4, 0));
        tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 4'hF, 1, 0, 1, 16'h1234, 2, 4'h0, 0));
        tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 4'hF, 1, 0, 0, 0, 0, 4'h0, 0));
        // reset to rr_ptr=0, then all four at once
        tbl.push_back(mk(1, 4'b0000, 0, 0, 0, 0, 4'hF, 1, 0, 0, 0, 0, 4'h0, 0));
        tbl.push_back(mk(0, 4'b1111, 16'h0A00, 16'h0A01, 16'h0A02, 16'h0A03, 4'hF, 1, 0, 0, 0, 0, 4'hF, 0));
        tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 4'hF, 1, 0, 1, 16'h0A00, 0, 4'hE, 0));
        tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 4'hF, 1, 0, 0, 0, 0, 4'hE, 0));
        tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 4'hF, 1, 0, 1, 16'h0A01, 1, 4'hC, 0));
        tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 4'hF, 1, 0, 0, 0, 0, 4'hC, 0));
        tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 4'hF, 1, 0, 1, 16'h0A02, 2, 4'h8, 0));
        tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 4'hF, 1, 0, 0, 0, 0, 4'h8, 0));
        tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 4'hF, 1, 0, 1, 16'h0A03, 3, 4'h0, 0));
        tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 4'hF, 1, 0, 0, 0, 0, 4'h0, 0));
        // move rr_ptr to 2 with one ch1 grant, then all four again
        tbl.push_back(mk(0, 4'b0010, 0, 16'h0B01, 0, 0, 4'hF, 1, 0, 0, 0, 0, 4'h2, 0));
        tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 4'hF, 1, 0, 1, 16'h0B01, 1, 4'h0, 0));
        tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 4'hF, 1, 0, 0, 0, 0, 4'h0, 0));
        tbl.push_back(mk(0, 4'b1111, 16'h0A00, 16'h0A01, 16'h0A02, 16'h0A03, 4'hF, 1, 0, 0, 0, 0, 4'hF, 0));
        tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 4'hF, 1, 0, 1, 16'h0A02, 2, 4'hB, 0));
        tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 4'hF, 1, 0, 0, 0, 0, 4'hB, 0));
        tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 4'hF, 1, 0, 1, 16'h0A03, 3, 4'h3, 0));
        tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 4'hF, 1, 0, 0, 0, 0, 4'h3, 0));
        tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 4'hF, 1, 0, 1, 16'h0A00, 0, 4'h2, 0));
        tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 4'hF, 1, 0, 0, 0, 0, 4'h2, 0));
        tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 4'hF, 1, 0, 1, 16'h0A01, 1, 4'h0, 0));
        tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 4'hF, 1, 0, 0, 0, 0, 4'h0, 0));
        // backpressure on ch1: 0001 out, 0002 held, 0003 dropped
        tbl.push_back(mk(0, 4'b0010, 0, 16'h0001, 0, 0, 4'hF, 0, 0, 0, 0, 0, 4'h2, 0));
        tbl.push_back(mk(0, 4'b0010, 0, 16'h0002, 0, 0, 4'hF, 0, 0, 1, 16'h0001, 1, 4'h2, 0));
        tbl.push_back(mk(0, 4'b0010, 0, 16'h0003, 0, 0, 4'hF, 0, 0, 1, 16'h0001, 1, 4'h2, 1));
        tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 4'hF, 0, 0, 1, 16'h0001, 1, 4'h2, 1));
        tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 4'hF, 1, 0, 0, 0, 0, 4'h2, 1));
        tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 4'hF, 1, 0, 1, 16'h0002, 1, 4'h0, 1));
        tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 4'hF, 1, 0, 0, 0, 0, 4'h0, 1));
        // disable ch3 while pending; disabled strobe ignored
        tbl.push_back(mk(0, 4'b1000, 0, 0, 0, 16'h0C03, 4'hF, 1, 0, 0, 0, 0, 4'h8, 1));
        tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 4'h7, 1, 0, 0, 0, 0, 4'h0, 1));
        tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 4'h7, 1, 0, 0, 0, 0, 4'h0, 1));
        tbl.push_back(mk(0, 4'b1000, 0, 0, 0, 16'h0C04, 4'h7, 1, 0, 0, 0, 0, 4'h0, 1));
        tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 4'hF, 1, 0, 0, 0, 0, 4'h0, 1));
        tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 4'hF, 1, 0, 0, 0, 0, 4'h0, 1));
        // grant with same-cycle recapture, then reset during SEND
        tbl.push_back(mk(0, 4'b0001, 16'h0D00, 0, 0, 0, 4'hF, 1, 0, 0, 0, 0, 4'h1, 1));
        tbl.push_back(mk(0, 4'b0001, 16'h0D01, 0, 0, 0, 4'hF, 0, 0, 1, 16'h0D00, 0, 4'h1, 1));
        tbl.push_back(mk(0, 4'b0010, 0, 16'h0D11, 0, 0, 4'hF, 0, 0, 1, 16'h0D00, 0, 4'h3, 1));
        tbl.push_back(mk(1, 4'b0000, 0, 0, 0, 0, 4'hF, 0, 0, 0, 0, 0, 4'h0, 0));
        tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 4'hF, 1, 0, 0, 0, 0, 4'h0, 0));

        // reset state
        drive(1'b1, 4'h0, 16'h0, 16'h0, 16'h0, 16'h0, 4'hF, 1'b1, 1'b0);
        drive(1'b1, 4'h0, 16'h0, 16'h0, 16'h0, 16'h0, 4'hF, 1'b1, 1'b0);
        chk("rst_vld", 32'(arb_vld), 32'd0);
        chk("rst_data", 32'(arb_data), 32'd0);
        chk("rst_ch", 32'(arb_ch), 32'd0);
        chk("rst_stamp", arb_stamp, 32'd0);
        chk("rst_pend", 32'(stu_pend), 32'd0);
        chk("rst_drop", 32'(stu_drop), 32'd0);

        foreach (tbl[i]) apply(tbl[i], i);

        // saturation: first cycle captures all, second grants ch0 and drops 3,
        // then each held cycle drops 4
        drive(1'b1, 4'h0, 16'h0, 16'h0, 16'h0, 16'h0, 4'hF, 1'b0, 1'b0);
        flood(1'b0);
        chk("sat_pend", 32'(stu_pend), 32'hF);
        flood(1'b0);
        chk("sat_first", 32'(stu_drop), 32'd3);
        for (int k = 0; k < 16382; k++) flood(1'b0);
        chk("sat_fffb", 32'(stu_drop), 32'hFFFB);
        flood(1'b0);
        chk("sat_ffff", 32'(stu_drop), 32'hFFFF);
        for (int k = 0; k < 1200; k++) flood(1'b0);
        chk("sat_hold", 32'(stu_drop), 32'hFFFF);
        chk("sat_out_vld", 32'(arb_vld), 32'd1);
        chk("sat_out_data", 32'(arb_data), 32'h0E00);
        chk("sat_out_ch", 32'(arb_ch), 32'd0);
        flood(1'b1);
        chk("clr_prio", 32'(stu_drop), 32'd0);
        flood(1'b0);
        chk("clr_resume", 32'(stu_drop), 32'd4);

        // timestamp: two ch0 captures five edges apart
        drive(1'b1, 4'h0, 16'h0, 16'h0, 16'h0, 16'h0, 4'hF, 1'b1, 1'b0);
        drive(1'b0, 4'h1, 16'h0F00, 16'h0, 16'h0, 16'h0, 4'hF, 1'b1, 1'b0);
        idle(1'b1);
        chk("ts_vld1", 32'(arb_vld), 32'd1);
        chk("ts_data1", 32'(arb_data), 32'h0F00);
        st1 = arb_stamp;
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        drive(1'b0, 4'h1, 16'h0F01, 16'h0, 16'h0, 16'h0, 4'hF, 1'b1, 1'b0);
        idle(1'b1);
        chk("ts_vld2", 32'(arb_vld), 32'd1);
        chk("ts_data2", 32'(arb_data), 32'h0F01);
        st2 = arb_stamp;
`ifdef PARA_ARB_STAMP_EN
        chk("ts_delta", st2 - st1, 32'd5);
`else
        chk("ts_zero1", st1, 32'd0);
        chk("ts_zero2", st2, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
